// File: rtl/song_fifo_player.sv
// ============================================================================
// Module   : song_fifo_player
// Brief    : Song FIFO reader; holds each note word for NOTE_TICKS cycles
//            and drives the tone synthesizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_fifo_player #(
  parameter int DATA_W     = 15,
  parameter int NOTE_TICKS = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_dout_i,
  input  logic              fifo_valid_i,
  output logic              fifo_rd_en_o,
  output logic [DATA_W-1:0] note_freq_o,
  output logic              note_active_o,
  output logic              note_start_o,
  output logic              song_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(NOTE_TICKS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   freq_q, freq_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                active_q, active_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play_i && !fifo_empty_i) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      // WAIT ignores play so a word already read is never dropped
      S_WAIT: begin
        if (fifo_valid_i) begin
          freq_d  = fifo_dout_i;
          cnt_d   = C_LOAD;
          start_d = 1'b1;
          state_d = S_PLAY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (play_i) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!fifo_empty_i) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
            freq_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so it lines up with note_freq and the pause level
    active_d = (state_d != S_IDLE) && play_i && (freq_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      freq_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      start_q  <= start_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign fifo_rd_en_o  = (state_q == S_FETCH);
  assign note_freq_o   = freq_q;
  assign note_active_o = active_q;
  assign note_start_o  = start_q;
  assign song_done_o   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_song_fifo_player.sv
// ============================================================================
// Module   : tb_song_fifo_player
// Brief    : Scoreboard bench for song_fifo_player with a small FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_fifo_player;

  localparam int DATA_W     = 15;
  localparam int NOTE_TICKS = 4;
  localparam int CNT_W      = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              play = 1'b0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_valid = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] note_freq;
  logic              note_active;
  logic              note_start;
  logic              song_done;

  song_fifo_player #(
    .DATA_W    (DATA_W),
    .NOTE_TICKS(NOTE_TICKS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .play_i       (play),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_valid_i (fifo_valid),
    .fifo_rd_en_o (fifo_rd_en),
    .note_freq_o  (note_freq),
    .note_active_o(note_active),
    .note_start_o (note_start),
    .song_done_o  (song_done)
  );

  initial forever #5 clk = ~clk;

  // FIFO model: 1-cycle read latency, valid the cycle after an accepted read
  logic [DATA_W-1:0] mem [0:15];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_cnt != rd_cnt)) begin
      fifo_dout  <= mem[rd_cnt % 16];
      fifo_valid <= 1'b1;
      rd_cnt     <= rd_cnt + 1;
    end else begin
      fifo_valid <= 1'b0;
    end
  end

  task automatic fifo_write(input logic [DATA_W-1:0] v);
    mem[wr_cnt % 16] = v;
    wr_cnt++;
  endtask

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: kind 0 = note_start with freq, kind 1 = song_done
  typedef struct {
    int kind;
    int freq;
    int gap;
  } ev_t;
  ev_t sb[$];

  task automatic expect_ev(input int kind, input int freq, input int gap);
    ev_t e;
    e.kind = kind; e.freq = freq; e.gap = gap;
    sb.push_back(e);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    int last_start;
    ev_t e;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 0);
      if (note_start) begin
        if (sb.size() == 0) begin
          chk("unexpected_note_start", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("start_kind", 32'(e.kind), 0);
          chk("start_freq", 32'(note_freq), 32'(e.freq));
          if (e.gap != 0) chk("start_spacing", 32'(cyc - last_start), 32'(e.gap));
        end
        last_start = cyc;
      end
      if (song_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_song_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 32'(e.kind), 1);
          chk("done_freq_zero", 32'(note_freq), 0);
        end
      end
    end
  end

  // Bounded wait, entered and left on a negedge
  task automatic wait_for(input int kind, input int maxc, input string nm);
    int n;
    n = 0;
    while (!((kind == 0) ? note_start : song_done) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!((kind == 0) ? note_start : song_done)) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic idle_checks(input string nm);
    repeat (20) begin
      @(negedge clk);
      chk(nm, {fifo_rd_en, note_start, song_done, note_active, 1'b0, note_freq}, 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int n;
    // Reset / idle with empty FIFO
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_freq", 32'(note_freq), 0);
    rst  = 1'b0;
    play = 1'b1;
    idle_checks("idle_empty");

    // Single note
    expect_ev(0, 440, 0);
    expect_ev(1, 0, 0);
    base = rd_cnt;
    fifo_write(440);
    wait_for(0, 10, "single_start");
    for (int i = 0; i < NOTE_TICKS; i++) begin
      chk("single_freq", 32'(note_freq), 440);
      chk("single_active", 32'(note_active), 1);
      chk("single_no_done", 32'(song_done), 0);
      @(negedge clk);
    end
    chk("single_done_pulse", 32'(song_done), 1);
    chk("single_reads", 32'(rd_cnt - base), 1);
    @(negedge clk);
    chk("single_done_one_cycle", 32'(song_done), 0);

    // Sequence with a rest
    expect_ev(0, 440, 0);
    expect_ev(0, 0, NOTE_TICKS + 2);
    expect_ev(0, 880, NOTE_TICKS + 2);
    expect_ev(1, 0, 0);
    fifo_write(440);
    fifo_write(0);
    fifo_write(880);
    wait_for(0, 10, "seq_first");
    @(negedge clk);
    wait_for(0, 10, "seq_rest");
    repeat (NOTE_TICKS) begin
      chk("rest_active", 32'(note_active), 0);
      chk("rest_freq", 32'(note_freq), 0);
      @(negedge clk);
    end
    wait_for(0, 10, "seq_880");
    chk("seq_880_active", 32'(note_active), 1);
    @(negedge clk);
    wait_for(1, 20, "seq_done");
    @(negedge clk);

    // Pause during a note
    expect_ev(0, 440, 0);
    expect_ev(1, 0, 0);
    fifo_write(440);
    wait_for(0, 10, "pause_start");
    chk("pause_active_before", 32'(note_active), 1);
    play = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("pause_active", 32'(note_active), 0);
      chk("pause_freq_held", 32'(note_freq), 440);
    end
    play = 1'b1;
    n = 0;
    while (!song_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pause_remaining_cycles", 32'(n), NOTE_TICKS);
    @(negedge clk);

    // Late write during a note, then a write after song_done
    expect_ev(0, 440, 0);
    expect_ev(0, 660, NOTE_TICKS + 2);
    expect_ev(1, 0, 0);
    fifo_write(440);
    wait_for(0, 10, "late_start");
    @(negedge clk);
    fifo_write(660);
    wait_for(1, 30, "late_done");
    repeat (4) @(negedge clk);
    expect_ev(0, 660, 0);
    expect_ev(1, 0, 0);
    fifo_write(660);
    wait_for(0, 10, "restart_start");
    chk("restart_freq", 32'(note_freq), 660);
    @(negedge clk);
    wait_for(1, 20, "restart_done");
    @(negedge clk);

    // Asynchronous reset mid-note
    expect_ev(0, 880, 0);
    fifo_write(880);
    wait_for(0, 10, "arst_start");
    @(negedge clk);
    chk("arst_freq_before", 32'(note_freq), 880);
    #2 rst = 1'b1;
    #1;
    chk("arst_freq", 32'(note_freq), 0);
    chk("arst_active", 32'(note_active), 0);
    chk("arst_rd_en", 32'(fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_checks("arst_idle");

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
